// File: rtl/commit_controller.sv
// In-order retirement from the ROB head: register writeback, store handshake with the LSB, mispredict flush.
// Outputs are registered and appear one cycle after the head is seen; `COMMIT_PERF_CNT_EN adds a 64-bit retired_cnt.
module commit_controller #(
    parameter int XLEN           = 32,
    parameter int REG_CNT_WIDTH  = 5,
    parameter int ROB_SIZE_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     rob_head_valid,
    input  logic                     rob_head_ready,
    input  logic                     rob_head_is_store,
    input  logic                     rob_head_mispred,
    input  logic [REG_CNT_WIDTH-1:0] rob_head_rd,
    input  logic [XLEN-1:0]          rob_head_val,
    input  logic [XLEN-1:0]          rob_head_target,
    input  logic                     store_ack,
    output logic                     commit_pop,
    output logic                     rf_we,
    output logic [REG_CNT_WIDTH-1:0] rf_rd,
    output logic [XLEN-1:0]          rf_val,
    output logic                     store_req,
    output logic                     flush,
    output logic [XLEN-1:0]          flush_pc
`ifdef COMMIT_PERF_CNT_EN
    ,
    output logic [63:0]              retired_cnt
`endif
);

    if (XLEN < 1 || REG_CNT_WIDTH < 1 || ROB_SIZE_WIDTH < 1) begin : g_param_check
        $error("commit_controller: XLEN, REG_CNT_WIDTH and ROB_SIZE_WIDTH must all be >= 1");
    end

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic                       commit_pop_q, commit_pop_d;
    logic                       rf_we_q, rf_we_d;
    logic [REG_CNT_WIDTH-1:0]   rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]            rf_val_q, rf_val_d;
    logic                       store_req_q, store_req_d;
    logic                       flush_q, flush_d;
    logic [XLEN-1:0]            flush_pc_q, flush_pc_d;
    logic                       head_go;

    // The ROB only advances its head on the edge after commit_pop, so the head seen
    // during a pop cycle is the entry being retired and must not be committed again.
    assign head_go = rob_head_valid & rob_head_ready & ~commit_pop_q;

    always_comb begin
        state_d      = state_q;
        commit_pop_d = 1'b0;
        rf_we_d      = 1'b0;
        rf_rd_d      = rf_rd_q;
        rf_val_d     = rf_val_q;
        store_req_d  = store_req_q;
        flush_d      = 1'b0;
        flush_pc_d   = flush_pc_q;

        if (rdy) begin
            unique case (state_q)
                RUN: begin
                    if (head_go) begin
                        if (rob_head_is_store) begin
                            store_req_d = 1'b1;
                            state_d     = STORE_WAIT;
                        end else begin
                            commit_pop_d = 1'b1;
                            rf_we_d      = (rob_head_rd != '0);
                            rf_rd_d      = rob_head_rd;
                            rf_val_d     = rob_head_val;
                            if (rob_head_mispred) begin
                                flush_d    = 1'b1;
                                flush_pc_d = rob_head_target;
                                state_d    = FLUSH;
                            end
                        end
                    end
                end
                STORE_WAIT: begin
                    if (store_ack) begin
                        store_req_d  = 1'b0;
                        commit_pop_d = 1'b1;
                        state_d      = RUN;
                    end
                end
                FLUSH: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            commit_pop_q <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_val_q     <= '0;
            store_req_q  <= 1'b0;
            flush_q      <= 1'b0;
            flush_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            commit_pop_q <= commit_pop_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_val_q     <= rf_val_d;
            store_req_q  <= store_req_d;
            flush_q      <= flush_d;
            flush_pc_q   <= flush_pc_d;
        end
    end

    assign commit_pop = commit_pop_q;
    assign rf_we      = rf_we_q;
    assign rf_rd      = rf_rd_q;
    assign rf_val     = rf_val_q;
    assign store_req  = store_req_q;
    assign flush      = flush_q;
    assign flush_pc   = flush_pc_q;

`ifdef COMMIT_PERF_CNT_EN
    logic [63:0] retired_cnt_q;

    // Counted on the edge that raises commit_pop so the count already includes the visible pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_q <= '0;
        end else if (commit_pop_d) begin
            retired_cnt_q <= retired_cnt_q + 64'd1;
        end
    end

    assign retired_cnt = retired_cnt_q;
`endif

endmodule
